shift_right_sticky_pipe: RTL and testbench
==========================================

Name: shift_right_sticky_pipe

Overview:
- Pipelined logical right shifter with sticky-bit generation.
- Counterpart of the combinational left shifter: realigns operands toward the LSB, e.g. for exponent alignment ahead of the adder in the posit/float datapath.
- One register stage per shift-amount bit.
- Valid/ready handshake on both sides, so it drops directly into backpressured arithmetic pipelines.

Parameters:
- DATA_WIDTH_A, 16, width of operand a.
- DATA_WIDTH_B, 4, width of shift amount b; also equals the number of pipeline stages.
- DATA_WIDTH_C, 16, width of result c.
  - Result is the low DATA_WIDTH_C bits of the shifted value.
  - Zero-extended when DATA_WIDTH_C > DATA_WIDTH_A.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- a  input  DATA_WIDTH_A  operand to shift.
- b  input  DATA_WIDTH_B  right-shift amount, unsigned.
- s_valid  input  1  a/b valid.
- s_ready  output  1  stage 0 can accept.
- c  output  DATA_WIDTH_C  shifted result.
- sticky  output  1  OR of all bits shifted out past bit 0.
- m_valid  output  1  c/sticky valid.
- m_ready  input  1  downstream accepts.

Behaviour:
- **Reset:** asynchronous, active-high. While rst is high:
  - All stage valid bits are 0; m_valid=0, c=0, sticky=0.
  - s_ready=1 once rst deasserts.
  - Data registers are cleared to 0.
- **Pipeline structure:** stage k (k=0..DATA_WIDTH_B-1) registers:
  - value_k = value_{k-1} >> 2^k if b[k]=1, else unchanged.
  - sticky_k = sticky_{k-1} | (OR of the 2^k bits shifted out when b[k]=1).
  - b and valid are carried alongside the data.
- **Latency:** exactly DATA_WIDTH_B cycles from the accepting edge (s_valid & s_ready) to m_valid, absent stalls.
- **Throughput:** one transfer per cycle.
- **Flow control:** global enable en = !m_valid | m_ready.
  - s_ready = en, combinational.
  - When en=0, every stage holds; c, sticky and m_valid must stay stable while m_valid=1 and m_ready=0 (AXI-stream rule).
  - Bubbles (valid=0 stages) advance when en=1; no bubble collapsing required.
- **Transfers:**
  - Input transfer on clk edge with s_valid & s_ready.
  - Output transfer on clk edge with m_valid & m_ready.
  - Simultaneous input and output transfer in the same cycle is allowed and is the steady-state case.
- **Width rules:**
  - Internal datapath is DATA_WIDTH_A bits wide. A stage whose shift 2^k >= DATA_WIDTH_A produces value 0 and sticky |= OR(all remaining bits).
  - Any b >= DATA_WIDTH_A therefore yields c=0 and sticky=|a.
  - b=0 yields c=a (resized) and sticky=0.
- **Input data gating:** a and b are ignored when s_valid=0; no X propagation into valid stages.
- **Reset mid-operation:** all in-flight items are discarded, m_valid drops asynchronously, no partial output afterwards.
- **State:** no FSM beyond per-stage valid bits.

Optional Feature:
- Macro: SHIFT_ARITH_EN.
- Defined:
  - Arithmetic right shift: vacated MSBs are filled with a[DATA_WIDTH_A-1], captured at stage 0 and carried through the pipe.
  - b >= DATA_WIDTH_A yields all bits equal to the sign.
  - sticky is computed exactly as in logical mode.
- Undefined: logical shift, zero fill.
- Ports and latency are identical in both builds.

Test Plan:
- Defaults; a=0x00F0, b=4, m_ready=1 -> 4 cycles later m_valid=1, c=0x000F, sticky=0, for exactly one cycle.
- a=0x8001, b=1 -> c=0x4000, sticky=1. a=0x1234, b=0 -> c=0x1234, sticky=0.
- a=0xFFFF, b=15 -> c=0x0001, sticky=1 in logical build; c=0xFFFF, sticky=1 with SHIFT_ARITH_EN defined.
- Stream 8 back-to-back items, m_ready low on cycles 5-7:
  - s_ready low on exactly those cycles.
  - c/sticky held stable while stalled.
  - All 8 results appear in order with none lost or duplicated.
  - Throughput returns to 1/cycle after the stall.
- Load 3 items, assert rst for 1 cycle mid-flight -> m_valid=0 immediately; no output for the pre-reset items; a new item (a=0x0100, b=8) afterwards gives c=0x0001, sticky=0 after 4 cycles.
- DATA_WIDTH_A=16, DATA_WIDTH_B=5, b=20, a=0x0003 -> c=0x0000, sticky=1, latency 5.

Source files
------------

// File: rtl/shift_right_sticky_pipe_if.sv
// Valid/ready bus bundle for shift_right_sticky_pipe: operand/shift-amount
// input side and result/sticky output side.
interface shift_right_sticky_pipe_if #(
  parameter int unsigned DATA_WIDTH_A = 16,
  parameter int unsigned DATA_WIDTH_B = 4,
  parameter int unsigned DATA_WIDTH_C = 16
);
  logic [DATA_WIDTH_A-1:0] a;
  logic [DATA_WIDTH_B-1:0] b;
  logic                    s_valid;
  logic                    s_ready;
  logic [DATA_WIDTH_C-1:0] c;
  logic                    sticky;
  logic                    m_valid;
  logic                    m_ready;

  // Producer of operands / consumer of results.
  modport master (
    output a, b, s_valid, m_ready,
    input  s_ready, c, sticky, m_valid
  );

  // The shifter itself.
  modport slave (
    input  a, b, s_valid, m_ready,
    output s_ready, c, sticky, m_valid
  );
endinterface

// File: rtl/shift_right_sticky_pipe.sv
// Pipelined right shifter with sticky-bit generation. Stage k applies the
// 2^k shift when b[k] is set; b, valid and sticky travel with the data.
// A single global enable (!m_valid | m_ready) stalls every stage at once.
// Optional build macro SHIFT_ARITH_EN: arithmetic shift (sign fill taken
// from a[MSB] at stage 0); default build is a logical (zero-fill) shift.
module shift_right_sticky_pipe #(
  parameter int unsigned DATA_WIDTH_A = 16,
  parameter int unsigned DATA_WIDTH_B = 4,
  parameter int unsigned DATA_WIDTH_C = 16
) (
  input logic                      clk,
  input logic                      rst,
  shift_right_sticky_pipe_if.slave bus
);

  localparam int unsigned AW = DATA_WIDTH_A;
  localparam int unsigned NB = DATA_WIDTH_B;
  localparam int unsigned CW = DATA_WIDTH_C;

  logic          en_c;
  logic [AW-1:0] out_val;
  logic          out_vld;
  logic          out_stk;

  for (genvar k = 0; k < NB; k++) begin : g_stage
    localparam int unsigned SH = 32'd1 << k;

    logic [AW-1:0] in_val;
    logic [NB-1:k] in_b;
    logic          in_vld;
    logic          in_stk;
    logic          fill_c;
    logic [AW-1:0] val_d;
    logic          stk_d;
    logic [AW-1:0] val_q;
    logic          vld_q;
    logic          stk_q;
`ifdef SHIFT_ARITH_EN
    logic          in_sgn;
`endif

    if (k == 0) begin : g_src
      // Operands are forced to zero when not valid so X never enters the pipe.
      assign in_vld = bus.s_valid;
      assign in_val = bus.s_valid ? bus.a : '0;
      assign in_b   = bus.s_valid ? bus.b : '0;
      assign in_stk = 1'b0;
`ifdef SHIFT_ARITH_EN
      assign in_sgn = bus.s_valid & bus.a[AW-1];
`endif
    end else begin : g_link
      // Each stage consumes the registered output of the previous one.
      assign in_vld = g_stage[k-1].vld_q;
      assign in_val = g_stage[k-1].val_q;
      assign in_b   = g_stage[k-1].g_fwd.b_q;
      assign in_stk = g_stage[k-1].stk_q;
`ifdef SHIFT_ARITH_EN
      assign in_sgn = g_stage[k-1].g_fwd.sgn_q;
`endif
    end

`ifdef SHIFT_ARITH_EN
    assign fill_c = in_sgn;
`else
    assign fill_c = 1'b0;
`endif

    if (SH >= AW) begin : g_flush
      // Shift covers the whole word: everything left falls into sticky.
      always_comb begin
        val_d = in_val;
        stk_d = in_stk;
        if (in_b[k]) begin
          val_d = {AW{fill_c}};
          stk_d = in_stk | (|in_val);
        end
      end
    end else begin : g_part
      localparam logic [AW-1:0] LO_MASK = {AW{1'b1}} >> (AW - SH);
      localparam logic [AW-1:0] HI_MASK = ~({AW{1'b1}} >> SH);

      // Partial shift: low SH bits feed sticky, vacated MSBs take the fill.
      always_comb begin
        val_d = in_val;
        stk_d = in_stk;
        if (in_b[k]) begin
          val_d = (in_val >> SH) | (fill_c ? HI_MASK : '0);
          stk_d = in_stk | (|(in_val & LO_MASK));
        end
      end
    end

    if (k < NB - 1) begin : g_fwd
      logic [NB-1:k+1] b_q;
`ifdef SHIFT_ARITH_EN
      logic            sgn_q;
`endif

      // Carry the not-yet-used shift bits (and sign) to later stages.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          b_q <= '0;
`ifdef SHIFT_ARITH_EN
          sgn_q <= 1'b0;
`endif
        end else if (en_c) begin
          b_q <= in_b[NB-1:k+1];
`ifdef SHIFT_ARITH_EN
          sgn_q <= in_sgn;
`endif
        end
      end
    end

    // Stage register: advances only on the global enable.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q <= 1'b0;
        val_q <= '0;
        stk_q <= 1'b0;
      end else if (en_c) begin
        vld_q <= in_vld;
        val_q <= val_d;
        stk_q <= stk_d;
      end
    end
  end

  assign out_val = g_stage[NB-1].val_q;
  assign out_vld = g_stage[NB-1].vld_q;
  assign out_stk = g_stage[NB-1].stk_q;

  // Whole pipe moves unless a result is waiting on a stalled consumer.
  assign en_c        = !out_vld | bus.m_ready;
  assign bus.s_ready = en_c;
  assign bus.m_valid = out_vld;
  assign bus.sticky  = out_stk;
  assign bus.c       = CW'(out_val);

endmodule

// File: tb/tb_shift_right_sticky_pipe.sv
// Directed bench for shift_right_sticky_pipe: a 4-stage and a 5-stage
// instance, single items, an 8-item stream with a stall, and mid-flight reset.
module tb_shift_right_sticky_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  shift_right_sticky_pipe_if #(.DATA_WIDTH_A(16), .DATA_WIDTH_B(4), .DATA_WIDTH_C(16)) i4 ();
  shift_right_sticky_pipe_if #(.DATA_WIDTH_A(16), .DATA_WIDTH_B(5), .DATA_WIDTH_C(16)) i5 ();

  shift_right_sticky_pipe #(.DATA_WIDTH_A(16), .DATA_WIDTH_B(4), .DATA_WIDTH_C(16)) dut4 (
    .clk(clk), .rst(rst), .bus(i4)
  );
  shift_right_sticky_pipe #(.DATA_WIDTH_A(16), .DATA_WIDTH_B(5), .DATA_WIDTH_C(16)) dut5 (
    .clk(clk), .rst(rst), .bus(i5)
  );

`ifdef SHIFT_ARITH_EN
  localparam logic [15:0] E_FFFF_15 = 16'hFFFF;
  localparam logic [15:0] E_8000_15 = 16'hFFFF;
  localparam logic [15:0] E_ABCD_7  = 16'hFF57;
  localparam logic [15:0] E_8000_16 = 16'hFFFF;
`else
  localparam logic [15:0] E_FFFF_15 = 16'h0001;
  localparam logic [15:0] E_8000_15 = 16'h0001;
  localparam logic [15:0] E_ABCD_7  = 16'h0157;
  localparam logic [15:0] E_8000_16 = 16'h0000;
`endif

  // Stream items (MSB clear, so identical in both shift modes).
  localparam logic [15:0] SA [8] = '{16'h0001, 16'h0003, 16'h00F0, 16'h0100,
                                     16'h7000, 16'h1235, 16'h4000, 16'h00FF};
  localparam logic [3:0]  SB [8] = '{4'd0, 4'd1, 4'd4, 4'd8, 4'd12, 4'd2, 4'd14, 4'd3};
  localparam logic [15:0] EC [8] = '{16'h0001, 16'h0001, 16'h000F, 16'h0001,
                                     16'h0007, 16'h048D, 16'h0001, 16'h001F};
  localparam logic        ES [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic mv(input bit big);
    return big ? i5.m_valid : i4.m_valid;
  endfunction

  // Send one item on an idle pipe and check latency, result and one-cycle m_valid.
  task automatic run_item(input bit big, input logic [15:0] av, input logic [4:0] bv,
                          input logic [15:0] ec, input logic es, input int lat,
                          input string tag);
    int n;
    if (big) begin
      i5.a = av; i5.b = bv; i5.s_valid = 1'b1;
    end else begin
      i4.a = av; i4.b = bv[3:0]; i4.s_valid = 1'b1;
    end
    tick();
    i4.s_valid = 1'b0; i5.s_valid = 1'b0;
    i4.a = 'x; i4.b = 'x; i5.a = 'x; i5.b = 'x;
    n = 1;
    while (!mv(big) && n < 12) begin
      tick();
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'(lat));
    check({tag, " c"}, 32'(big ? i5.c : i4.c), 32'(ec));
    check({tag, " sticky"}, 32'(big ? i5.sticky : i4.sticky), 32'(es));
    tick();
    check({tag, " m_valid one cycle"}, 32'(mv(big)), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    int idx;
    int outs;
    int last_cyc;
    int seen;
    logic [15:0] hold_c;
    logic        hold_s;

    i4.a = '0; i4.b = '0; i4.s_valid = 1'b0; i4.m_ready = 1'b1;
    i5.a = '0; i5.b = '0; i5.s_valid = 1'b0; i5.m_ready = 1'b1;

    // Reset state.
    tick(); tick();
    check("reset m_valid4", 32'(i4.m_valid), 32'd0);
    check("reset c4", 32'(i4.c), 32'd0);
    check("reset sticky4", 32'(i4.sticky), 32'd0);
    check("reset m_valid5", 32'(i5.m_valid), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("post-reset s_ready4", 32'(i4.s_ready), 32'd1);
    check("post-reset s_ready5", 32'(i5.s_ready), 32'd1);
    tick();

    // Single items on the 4-stage instance.
    run_item(1'b0, 16'h00F0, 5'd4,  16'h000F, 1'b0, 4, "f0>>4");
    run_item(1'b0, 16'h8001, 5'd1,  16'h4000, 1'b1, 4, "8001>>1");
    run_item(1'b0, 16'h1234, 5'd0,  16'h1234, 1'b0, 4, "1234>>0");
    run_item(1'b0, 16'hFFFF, 5'd15, E_FFFF_15, 1'b1, 4, "ffff>>15");
    run_item(1'b0, 16'h8000, 5'd15, E_8000_15, 1'b0, 4, "8000>>15");
    run_item(1'b0, 16'hABCD, 5'd7,  E_ABCD_7,  1'b1, 4, "abcd>>7");
    run_item(1'b0, 16'h7FFF, 5'd8,  16'h007F, 1'b1, 4, "7fff>>8");

    // 5-stage instance: shift amounts at and beyond the operand width.
    run_item(1'b1, 16'h0003, 5'd20, 16'h0000, 1'b1, 5, "w5 0003>>20");
    run_item(1'b1, 16'h8000, 5'd16, E_8000_16, 1'b1, 5, "w5 8000>>16");
    run_item(1'b1, 16'h0000, 5'd31, 16'h0000, 1'b0, 5, "w5 0000>>31");
    run_item(1'b1, 16'h0F00, 5'd9,  16'h0007, 1'b1, 5, "w5 0f00>>9");

    // Stream of 8 items with m_ready low on cycles 5..7.
    idx = 0; outs = 0; last_cyc = 0;
    hold_c = '0; hold_s = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      i4.m_ready = !(cyc >= 5 && cyc <= 7);
      i4.s_valid = (idx < 8);
      if (idx < 8) begin
        i4.a = SA[idx]; i4.b = SB[idx];
      end
      #1;
      check("stream s_ready", 32'(i4.s_ready), 32'(!(cyc >= 5 && cyc <= 7)));
      if (cyc == 5) begin
        hold_c = i4.c; hold_s = i4.sticky;
      end
      if (cyc >= 6 && cyc <= 7) begin
        check("stall m_valid", 32'(i4.m_valid), 32'd1);
        check("stall c held", 32'(i4.c), 32'(hold_c));
        check("stall sticky held", 32'(i4.sticky), 32'(hold_s));
      end
      if (i4.m_valid && i4.m_ready) begin
        if (outs < 8) begin
          check("stream c", 32'(i4.c), 32'(EC[outs]));
          check("stream sticky", 32'(i4.sticky), 32'(ES[outs]));
        end
        outs++;
        last_cyc = cyc;
      end
      if (i4.s_valid && i4.s_ready) idx++;
      tick();
    end
    i4.s_valid = 1'b0;
    check("stream accepted", 32'(idx), 32'd8);
    check("stream delivered", 32'(outs), 32'd8);
    check("stream last out cycle", 32'(last_cyc), 32'd15);

    // Reset mid-flight with three items in the pipe and one held at the output.
    i4.m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      i4.s_valid = 1'b1; i4.a = 16'h0F00 + 16'(i); i4.b = 4'd4;
      tick();
    end
    i4.s_valid = 1'b0;
    tick();
    check("pre-reset m_valid", 32'(i4.m_valid), 32'd1);
    check("pre-reset c", 32'(i4.c), 32'h00F0);
    rst = 1'b1;
    #1;
    check("mid-reset m_valid", 32'(i4.m_valid), 32'd0);
    check("mid-reset c", 32'(i4.c), 32'd0);
    check("mid-reset s_ready", 32'(i4.s_ready), 32'd1);
    tick();
    rst = 1'b0;
    i4.m_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i4.m_valid) seen++;
    end
    check("no stale output", 32'(seen), 32'd0);
    run_item(1'b0, 16'h0100, 5'd8, 16'h0001, 1'b0, 4, "post-reset 0100>>8");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
